// File: rtl/bsg_fifo_rolly_replay_tx.sv
// Read-side controller for a rolly FIFO: streams windows of beats onto a link, then waits for
// a remote ack (release window) or nack/timeout (roll the FIFO back and replay the window).
module bsg_fifo_rolly_replay_tx #(
  parameter int unsigned width_p       = 8,
  parameter int unsigned window_p      = 8,
  parameter int unsigned timeout_p     = 255,
  parameter int unsigned max_retries_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] fifo_data_i,
  input  logic               fifo_v_i,
  output logic               fifo_yumi_o,
  output logic               fifo_rollback_v_o,
  output logic               fifo_ack_v_o,
  output logic [width_p-1:0] link_data_o,
  output logic               link_v_o,
  input  logic               link_ready_i,
  output logic               link_replay_o,
  input  logic               resp_v_i,
  input  logic               resp_ack_i,
  output logic               error_o
);

  localparam int unsigned SentW  = $clog2(window_p + 1);
  localparam int unsigned TimerW = $clog2(timeout_p + 1);
  localparam int unsigned RetryW = $clog2(max_retries_p + 2);

  localparam logic [SentW-1:0]  WindowFull  = SentW'(window_p);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(timeout_p - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(max_retries_p);

  typedef enum logic [2:0] {StSend, StWait, StAck, StRollback, StHalt} state_e;

  state_e             state_q, state_d;
  logic [SentW-1:0]   sent_cnt_q, sent_cnt_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [RetryW-1:0]  retry_cnt_q, retry_cnt_d;
  logic               error_q, error_d;

  logic               link_v;
  logic               yumi;
  logic               nack;
  logic [SentW-1:0]   sent_inc;

  assign sent_inc = sent_cnt_q + SentW'(1);

  always_comb begin
    state_d     = state_q;
    sent_cnt_d  = sent_cnt_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    error_d     = error_q;
    link_v      = 1'b0;
    yumi        = 1'b0;
    nack        = 1'b0;

    unique case (state_q)
      StSend: begin
        link_v = fifo_v_i & (sent_cnt_q < WindowFull);
        yumi   = link_v & link_ready_i;
        if (yumi) begin
          sent_cnt_d = sent_inc;
          if (sent_inc == WindowFull) state_d = StWait;
        end else if (!fifo_v_i && (sent_cnt_q != '0)) begin
          // FIFO ran dry mid-window: close the partial window
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (resp_v_i) begin
          if (resp_ack_i) state_d = StAck;
          else            nack    = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          nack = 1'b1;
        end
        if (nack) begin
          if (retry_cnt_q == RetryMax) begin
            state_d = StHalt;
            error_d = 1'b1;
          end else begin
            retry_cnt_d = retry_cnt_q + RetryW'(1);
            state_d     = StRollback;
          end
        end
      end
      StAck: begin
        sent_cnt_d  = '0;
        timer_d     = '0;
        retry_cnt_d = '0;
        state_d     = StSend;
      end
      StRollback: begin
        sent_cnt_d = '0;
        timer_d    = '0;
        state_d    = StSend;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StSend;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StSend;
      sent_cnt_q  <= '0;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sent_cnt_q  <= sent_cnt_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      error_q     <= error_d;
    end
  end

  // Handshake outputs are held low combinationally while reset is asserted
  assign link_v_o          = link_v & reset_n_i;
  assign fifo_yumi_o       = yumi & reset_n_i;
  assign fifo_ack_v_o      = (state_q == StAck) & reset_n_i;
  assign fifo_rollback_v_o = (state_q == StRollback) & reset_n_i;
  assign link_data_o       = fifo_data_i;
  assign link_replay_o     = (retry_cnt_q != '0) & link_v_o;
  assign error_o           = error_q;

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_tx.sv
// Bench for bsg_fifo_rolly_replay_tx: a rolly-FIFO model feeds the DUT, a behavioural model
// predicts every output each cycle, and directed scenarios pin timing with literal counts.
module tb_bsg_fifo_rolly_replay_tx;
  localparam int DW = 8, WIN = 4, TO = 10, MR = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] fifo_data = '0, link_data;
  logic          fifo_v = 1'b0, ready = 1'b0, resp_v = 1'b0, resp_ack = 1'b0;
  logic          yumi, rb, ack, link_v, replay, err_o;

  always #5 clk = ~clk;

  bsg_fifo_rolly_replay_tx #(.width_p(DW), .window_p(WIN), .timeout_p(TO),
                             .max_retries_p(MR)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .fifo_data_i(fifo_data), .fifo_v_i(fifo_v),
    .fifo_yumi_o(yumi), .fifo_rollback_v_o(rb), .fifo_ack_v_o(ack), .link_data_o(link_data),
    .link_v_o(link_v), .link_ready_i(ready), .link_replay_o(replay), .resp_v_i(resp_v),
    .resp_ack_i(resp_ack), .error_o(err_o));

  int n_cmp = 0, n_bad = 0;

  // Rolly FIFO model: read pointer, committed read pointer, write pointer
  logic [DW-1:0] mem [0:255];
  int wptr = 0, rptr = 0, rcptr = 0;

  // Behavioural model: 0 sending, 1 waiting, 2 acking, 3 rolling back, 4 halted
  int phase = 0, sent = 0, tmr = 0, retries = 0;
  bit err = 0;

  int cyc = 0, yumi_cnt = 0, ack_cnt = 0, rb_cnt = 0, replay_cnt = 0, rb_cyc = -1;
  logic [DW-1:0] delivered [$];
  bit ready_toggle = 0, auto_ack = 0, resp_v_nx = 0, resp_ack_nx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not reached within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr] = DW'(wptr * 37 + 5);
      wptr++;
    end
  endtask

  task automatic step();
    bit e_lv, e_y, nk;
    @(negedge clk);
    fifo_v    = (rptr < wptr);
    fifo_data = fifo_v ? mem[rptr] : '0;
    ready     = ready_toggle ? (cyc % 2 == 0) : 1'b1;
    if (auto_ack && phase == 1) begin
      resp_v = 1'b1; resp_ack = 1'b1;
    end else begin
      resp_v = resp_v_nx; resp_ack = resp_ack_nx;
    end
    resp_v_nx = 0; resp_ack_nx = 0;
    #2;
    e_lv = (phase == 0) && fifo_v && (sent < WIN);
    e_y  = e_lv && ready;
    chk("link_v", link_v, e_lv);
    chk("yumi", yumi, e_y);
    chk("ack_pulse", ack, phase == 2);
    chk("rollback_pulse", rb, phase == 3);
    chk("replay", replay, (retries != 0) && e_lv);
    chk("error", err_o, err);
    if (e_lv) chk("link_data", link_data, mem[rptr]);
    if (yumi) begin
      yumi_cnt++;
      delivered.push_back(link_data);
      if (replay) replay_cnt++;
    end
    if (ack) ack_cnt++;
    if (rb) begin rb_cnt++; rb_cyc = cyc; end
    // Advance model to the state after the coming edge
    nk = 0;
    case (phase)
      0: begin
        if (e_y) begin
          sent++;
          if (sent == WIN) phase = 1;
        end else if (!fifo_v && sent != 0) phase = 1;
      end
      1: begin
        if (resp_v) begin
          if (resp_ack) phase = 2; else nk = 1;
        end else if (tmr == TO - 1) nk = 1;
        tmr++;
        if (nk) begin
          if (retries == MR) begin phase = 4; err = 1; end
          else begin retries++; phase = 3; end
        end
      end
      2: begin sent = 0; tmr = 0; retries = 0; phase = 0; end
      3: begin sent = 0; tmr = 0; phase = 0; end
      default: ;
    endcase
    if (e_y) rptr++;
    if (ack) rcptr = rptr;
    if (rb) rptr = rcptr;
    cyc++;
  endtask

  task automatic wait_phase(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (phase == target) return;
      step();
    end
    if (phase != target) bound_fail(name);
  endtask

  task automatic finish_ack();
    wait_phase(1, 30, "finish_ack_wait");
    resp_v_nx = 1; resp_ack_nx = 1;
    step();
    step();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0; fifo_v = 1'b0; resp_v = 1'b0; resp_ack = 1'b0;
    #2;
    chk({name, "_link_v"}, link_v, 0);
    chk({name, "_yumi"}, yumi, 0);
    chk({name, "_ack"}, ack, 0);
    chk({name, "_rollback"}, rb, 0);
    chk({name, "_error"}, err_o, 0);
    phase = 0; sent = 0; tmr = 0; retries = 0; err = 0;
    wptr = 0; rptr = 0; rcptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int y0, a0, r0, rp0, w0, d0, base;

  initial begin
    do_reset("init");

    // 1: full window of 4, ack releases it
    push(4);
    y0 = yumi_cnt;
    repeat (4) step();
    chk("t1_yumis", yumi_cnt - y0, 4);
    step();
    chk("t1_wait_no_beat", link_v, 0);
    resp_v_nx = 1; resp_ack_nx = 1;
    step();
    a0 = ack_cnt;
    step();
    chk("t1_ack_pulses", ack_cnt - a0, 1);
    repeat (2) step();

    // 2: partial window of 3, nack replays it, ack clears replay flag
    push(3);
    y0 = yumi_cnt;
    wait_phase(1, 20, "t2_wait");
    chk("t2_yumis", yumi_cnt - y0, 3);
    resp_v_nx = 1; resp_ack_nx = 0;
    step();
    r0 = rb_cnt; rp0 = replay_cnt;
    step();
    chk("t2_rollbacks", rb_cnt - r0, 1);
    wait_phase(1, 20, "t2_replay_wait");
    chk("t2_replay_beats", replay_cnt - rp0, 3);
    for (int i = 0; i < 3; i++)
      chk("t2_replay_data", delivered[delivered.size() - 3 + i], mem[wptr - 3 + i]);
    finish_ack();
    push(1);
    step();
    chk("t2_fresh_beat_valid", link_v, 1);
    chk("t2_replay_cleared", replay, 0);
    finish_ack();

    // 3: timeout rollback latency, then response in the last wait cycle wins
    push(2);
    wait_phase(1, 20, "t3_wait");
    w0 = cyc; rb_cyc = -1;
    for (int i = 0; i < 15 && rb_cyc < 0; i++) step();
    chk("t3_timeout_latency", rb_cyc - w0, 10);
    wait_phase(1, 20, "t3_replay_wait");
    repeat (9) step();
    resp_v_nx = 1; resp_ack_nx = 1;
    step();
    a0 = ack_cnt; r0 = rb_cnt;
    step();
    chk("t3_resp_wins_ack", ack_cnt - a0, 1);
    chk("t3_resp_wins_no_rb", rb_cnt - r0, 0);

    // 4: three nacks with max_retries_p=2 -> two rollbacks, then halt
    push(1);
    r0 = rb_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_phase(1, 30, "t4_wait");
      resp_v_nx = 1; resp_ack_nx = 0;
      step();
    end
    step();
    chk("t4_rollbacks", rb_cnt - r0, 2);
    chk("t4_error", err_o, 1);
    push(3);
    y0 = yumi_cnt;
    repeat (5) step();
    chk("t4_halt_no_yumi", yumi_cnt - y0, 0);
    do_reset("t4_reset");

    // 5: link_ready toggling, 12 beats across three acked windows
    ready_toggle = 1; auto_ack = 1;
    d0 = delivered.size(); base = wptr;
    push(12);
    for (int i = 0; i < 200 && !(rcptr == wptr && phase == 0); i++) step();
    if (!(rcptr == wptr && phase == 0)) bound_fail("t5_drain");
    chk("t5_beat_count", delivered.size() - d0, 12);
    for (int i = 0; i < 12 && d0 + i < delivered.size(); i++)
      chk("t5_beat_order", delivered[d0 + i], mem[base + i]);
    ready_toggle = 0; auto_ack = 0;

    // 6: reset while waiting and while rolling back
    push(2);
    wait_phase(1, 20, "t6_wait");
    step();
    do_reset("t6_reset_wait");
    push(1);
    step();
    chk("t6_send_after_wait_reset", link_v, 1);
    finish_ack();
    push(1);
    wait_phase(1, 20, "t6_wait2");
    resp_v_nx = 1; resp_ack_nx = 0;
    step();
    do_reset("t6_reset_rollback");
    push(1);
    step();
    chk("t6_send_after_rb_reset", link_v, 1);
    chk("t6_no_replay_after_reset", replay, 0);
    finish_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
